// File: rtl/bird_pkg.sv
// bird_pkg: shared state encoding, screen defaults and sub-pixel width helper
package bird_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} bird_state_e;
  localparam int SCREEN_H = 480;
  localparam int BIRD_H = 24;
  function automatic int sub_w(input int y_w, input int frac_w);
    return y_w + frac_w + 2;
  endfunction
endpackage

// File: rtl/bird_tick_gen.sv
// bird_tick_gen: pausable divider producing a registered one-cycle physics tick
module bird_tick_gen #(
  parameter int TICK_DIV = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic pause_i,
  output logic tick_o
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d, wrap;
  assign wrap = cnt_q == CW'(TICK_DIV - 1);
  // counter freezes while paused, so a pending wrap fires only after release
  always_comb begin
    cnt_d = pause_i ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    tick_d = !pause_i && wrap;
  end
  // counter and tick pulse registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  assign tick_o = tick_q;
endmodule

// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: sub-pixel bird physics FSM; optional flap cooldown via BIRD_FLAP_COOLDOWN_EN
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int Y_W = 10,
  parameter int FRAC_W = 4,
  parameter int TICK_DIV = 1048576,
  parameter int GRAVITY = 16,
  parameter int FLAP_VEL = -112,
  parameter int MAX_FALL = 64,
  parameter int SCREEN_H = bird_pkg::SCREEN_H,
  parameter int BIRD_H = bird_pkg::BIRD_H,
  parameter int START_Y = 200
`ifdef BIRD_FLAP_COOLDOWN_EN
  ,
  parameter int COOLDOWN_TICKS = 3
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flap_btn,
  input  logic                        collision,
  input  logic                        pause,
  output logic [Y_W-1:0]              bird_y,
  output logic signed [Y_W+FRAC_W+1:0] velocity,
  output logic [1:0]                  state,
  output logic                        alive,
  output logic                        game_over,
  output logic                        phys_tick
);
  localparam int PW = Y_W + FRAC_W;
  localparam int VW = sub_w(Y_W, FRAC_W);
  localparam logic signed [VW-1:0] FLOOR = VW'((SCREEN_H - BIRD_H) * (2 ** FRAC_W));
  localparam logic [PW-1:0] POS0 = PW'(START_Y * (2 ** FRAC_W));
  bird_state_e st_q, st_d;
  logic [PW-1:0] pos_q, pos_d;
  logic signed [VW-1:0] vel_q, vel_d, pos_s, np, vg, sat, pos_n;
  logic flap_q, flap_d, col_q, col_d, btn_q, cd_ok, tick;
  bird_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .pause_i(pause),
    .tick_o(tick)
  );
`ifdef BIRD_FLAP_COOLDOWN_EN
  localparam int CDW = $clog2(COOLDOWN_TICKS + 1);
  logic [CDW-1:0] cd_q, cd_d;
  logic acc;
  assign acc = tick && flap_q && (st_q == IDLE || (st_q == PLAY && !col_q));
  // cooldown reloads on an accepted flap and counts ticks down to zero
  always_comb cd_d = !tick ? cd_q : acc ? CDW'(COOLDOWN_TICKS) : (cd_q != '0) ? cd_q - 1'b1 : cd_q;
  // cooldown register
  always_ff @(posedge clk or posedge reset)
    if (reset) cd_q <= '0;
    else cd_q <= cd_d;
  assign cd_ok = cd_q == '0;
`else
  assign cd_ok = 1'b1;
`endif
  // physics step on each tick plus flap/collision latch maintenance
  always_comb begin
    pos_s = {2'b00, pos_q};
    np = pos_s + vel_q;
    vg = vel_q + VW'(GRAVITY);
    sat = (vg > VW'(MAX_FALL)) ? VW'(MAX_FALL) : vg;
    st_d = st_q;
    pos_n = pos_s;
    vel_d = vel_q;
    if (tick)
      case (st_q)
        IDLE: if (flap_q) begin
          vel_d = VW'(FLAP_VEL);
          pos_n = pos_s + VW'(FLAP_VEL);
          st_d = PLAY;
        end
        PLAY: if (col_q) begin
          vel_d = '0;
          st_d = DYING;
        end else begin
          vel_d = flap_q ? VW'(FLAP_VEL) : sat;
          pos_n = np;
          if (np <= 0) begin
            pos_n = '0;
            vel_d = '0;
            st_d = OVER;
          end else if (np >= FLOOR) begin
            pos_n = FLOOR;
            vel_d = '0;
            st_d = OVER;
          end
        end
        DYING: begin
          vel_d = sat;
          pos_n = np;
          if (np >= FLOOR) begin
            pos_n = FLOOR;
            vel_d = '0;
            st_d = OVER;
          end
        end
        default: ;
      endcase
    pos_d = pos_n[PW-1:0];
    flap_d = (st_q == IDLE || st_q == PLAY) && ((flap_btn && !btn_q && cd_ok) || (flap_q && !tick));
    col_d = st_q == PLAY && (collision || (col_q && !tick));
  end
  // state, motion and latch registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      pos_q <= POS0;
      vel_q <= '0;
      flap_q <= 1'b0;
      col_q <= 1'b0;
      btn_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pos_q <= pos_d;
      vel_q <= vel_d;
      flap_q <= flap_d;
      col_q <= col_d;
      btn_q <= flap_btn;
    end
  assign bird_y = pos_q[PW-1:FRAC_W];
  assign velocity = vel_q;
  assign state = st_q;
  assign alive = st_q == PLAY;
  assign game_over = st_q == OVER;
  assign phys_tick = tick;
endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb_bird_motion_ctrl: directed and random checks of the bird engine against a per-tick model
module tb_bird_motion_ctrl;
  localparam int FLOOR = 456 * 16;
  localparam int FLAP = -112;
  localparam int GRAV = 16;
  localparam int MAXF = 64;
  localparam int Y0 = 200 * 16;
  logic clk = 0, reset = 1, flap_btn = 0, collision = 0, pause = 0;
  logic [9:0] bird_y;
  logic signed [15:0] velocity;
  logic [1:0] state;
  logic alive, game_over, phys_tick;
  int total = 0, bad = 0;
  int m_pos, m_vel, m_st, n, vmax, loads;
  bit pf, pc;
`ifdef BIRD_FLAP_COOLDOWN_EN
  int cd;
`endif
  bird_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .flap_btn(flap_btn), .collision(collision), .pause(pause),
    .bird_y(bird_y), .velocity(velocity), .state(state), .alive(alive),
    .game_over(game_over), .phys_tick(phys_tick)
  );
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask
  task automatic check_model();
    chk("bird_y", 32'(bird_y), 32'(m_pos / 16));
    chk("velocity", 32'(velocity), 32'(m_vel));
    chk("state", 32'(state), 32'(m_st));
    chk("alive", 32'(alive), 32'(m_st == 1));
    chk("game_over", 32'(game_over), 32'(m_st == 3));
    chk("tick_low", 32'(phys_tick), 0);
  endtask
  task automatic model_reset();
    m_pos = Y0; m_vel = 0; m_st = 0; pf = 0; pc = 0;
`ifdef BIRD_FLAP_COOLDOWN_EN
    cd = 0;
`endif
  endtask
  task automatic model_tick();
    int np, vg;
    bit acc;
    np = m_pos + m_vel;
    vg = (m_vel + GRAV > MAXF) ? MAXF : m_vel + GRAV;
    acc = 0;
    if (m_st == 0) begin
      if (pf) begin m_vel = FLAP; m_pos += FLAP; m_st = 1; acc = 1; end
    end else if (m_st == 1) begin
      if (pc) begin m_vel = 0; m_st = 2; end
      else begin
        acc = pf;
        m_vel = pf ? FLAP : vg;
        if (np <= 0) begin m_pos = 0; m_vel = 0; m_st = 3; end
        else if (np >= FLOOR) begin m_pos = FLOOR; m_vel = 0; m_st = 3; end
        else m_pos = np;
      end
    end else if (m_st == 2) begin
      m_vel = vg;
      if (np >= FLOOR) begin m_pos = FLOOR; m_vel = 0; m_st = 3; end
      else m_pos = np;
    end
`ifdef BIRD_FLAP_COOLDOWN_EN
    cd = acc ? 3 : (cd > 0) ? cd - 1 : 0;
`else
    if (acc) loads = loads;
`endif
    pf = 0; pc = 0;
  endtask
  task automatic do_reset();
    reset = 1; flap_btn = 0; collision = 0; pause = 0;
    @(posedge clk); #1;
    model_reset();
    check_model();
    reset = 0;
  endtask
  task automatic tick(input bit f, input bit c, input bit hold);
    bit seen, g;
    g = 1;
`ifdef BIRD_FLAP_COOLDOWN_EN
    g = (cd == 0);
`endif
    if (f && !flap_btn && m_st <= 1 && g) pf = 1;
    if (c && m_st == 1) pc = 1;
    flap_btn = f; collision = c;
    @(posedge clk); #1;
    if (!hold) flap_btn = 0;
    collision = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = phys_tick;
    end
    chk("tick_seen", 32'(seen), 1);
    if (seen) begin
      @(posedge clk); #1;
      model_tick();
      check_model();
      if (int'(velocity) > vmax) vmax = int'(velocity);
      if (velocity == 16'(FLAP)) loads++;
    end
  endtask
  task automatic do_pause();
    int k;
    k = $urandom_range(0, 2);
    repeat (k) begin @(posedge clk); #1; end
    pause = 1;
    repeat (20) begin
      @(negedge clk);
      chk("pause_y", 32'(bird_y), 32'(m_pos / 16));
      chk("pause_v", 32'(velocity), 32'(m_vel));
      chk("pause_tick", 32'(phys_tick), 0);
    end
    @(posedge clk); #1;
    pause = 0;
    tick(0, 0, 0);
  endtask
  initial begin
    loads = 0; vmax = -1000;
    do_reset();
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("idle_hold", 32'(state), 0);
    tick(1, 0, 0);
    chk("start_y", 32'(bird_y), 193);
    chk("start_v", 32'(velocity), -112);
    chk("start_alive", 32'(alive), 1);
    tick(0, 0, 0);
    chk("second_y", 32'(bird_y), 186);
    chk("second_v", 32'(velocity), -96);
    loads = 0;
    repeat (10) tick(1, 0, 1);
    chk("hold_loads", 32'(loads), 1);
    tick(0, 0, 0);
    do_pause();
    vmax = -1000; n = 0;
    while (m_st != 3 && n < 200) begin tick(0, 0, 0); n++; end
    chk("fall_vmax", 32'(vmax), 64);
    chk("floor_y", 32'(bird_y), 456);
    chk("floor_over", 32'(game_over), 1);
    repeat (3) tick(1, 1, 0);
    chk("over_hold", 32'(state), 3);
    do_reset();
    n = 0;
    while (m_st != 3 && n < 100) begin tick(1, 0, 0); n++; end
`ifndef BIRD_FLAP_COOLDOWN_EN
    chk("ceil_y", 32'(bird_y), 0);
    chk("ceil_v", 32'(velocity), 0);
    chk("ceil_over", 32'(state), 3);
`else
    do_reset();
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    chk("cool_v", 32'(velocity), -80);
`endif
    do_reset();
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("die_state", 32'(state), 2);
    chk("die_alive", 32'(alive), 0);
    chk("die_v", 32'(velocity), 0);
    n = 0;
    while (m_st != 3 && n < 200) begin tick(n[0], 0, 0); n++; end
    chk("die_floor", 32'(bird_y), 456);
    do_reset();
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    chk("pre_areset", 32'(state), 2);
    #3 reset = 1;
    #1;
    chk("areset_y", 32'(bird_y), 200);
    chk("areset_state", 32'(state), 0);
    chk("areset_v", 32'(velocity), 0);
    @(posedge clk); #1;
    model_reset();
    reset = 0;
    repeat (6) begin
      do_reset();
      tick(1, 0, 0);
      n = 0;
      while (m_st != 3 && n < 80) begin
        tick($urandom_range(0, 3) == 0, $urandom_range(0, 30) == 0, 0);
        if ($urandom_range(0, 9) == 0) do_pause();
        n++;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
